// File: rtl/ocm_read_master_if.sv
// Memory-side (Avalon-MM read) and stream-side (Avalon-ST source) signals of
// the on-chip-memory read master.
interface ocm_read_master_if #(
  parameter int ADDR_W = 15
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_read;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_readdata;

  logic [31:0]       src_data;
  logic              src_valid;
  logic              src_ready;
  logic              src_sop;
  logic              src_eop;

  modport master (
    output avm_address, avm_chipselect, avm_read, avm_write, avm_byteenable,
    input  avm_readdata,
    output src_data, src_valid, src_sop, src_eop,
    input  src_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_read, avm_write, avm_byteenable,
    output avm_readdata,
    input  src_data, src_valid, src_sop, src_eop,
    output src_ready
  );
endinterface

// File: rtl/ocm_read_master.sv
// Streams word_count consecutive words from fixed-latency on-chip memory into
// an Avalon-ST source, with a small credit-limited FIFO absorbing backpressure.
module ocm_read_master #(
  parameter int ADDR_W     = 15,
  parameter int MEM_WORDS  = 25600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  ocm_read_master_if.master bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       issue_left;
  logic [15:0]       out_left;
  logic [15:0]       total;
  logic              rd_vld;
  logic              done_zero;

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     occ;

  logic              rd_go;
  logic              push;
  logic              pop;
  logic              last_acc;

  // Credit check counts words already buffered plus the one read in flight, so
  // every returning word is guaranteed a free slot.
  assign rd_go    = (state == FETCH) && (issue_left != 16'd0) &&
                    ((occ + CW'(rd_vld)) < CW'(FIFO_DEPTH));
  assign push     = rd_vld;
  assign pop      = bus.src_valid && bus.src_ready;
  assign last_acc = pop && (out_left == 16'd1);

  assign busy               = (state != IDLE);
  assign done               = done_zero || ((state == DRAIN) && last_acc);

  assign bus.avm_address    = addr;
  assign bus.avm_read       = rd_go;
  assign bus.avm_chipselect = rd_go;
  assign bus.avm_write      = 1'b0;
  assign bus.avm_byteenable = 4'hF;

  assign bus.src_valid      = (occ != '0);
  assign bus.src_data       = fifo_mem[rd_ptr];
  assign bus.src_sop        = bus.src_valid && (out_left == total);
  assign bus.src_eop        = bus.src_valid && (out_left == 16'd1);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.avm_readdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      issue_left <= '0;
      out_left   <= '0;
      total      <= '0;
      rd_vld     <= 1'b0;
      done_zero  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
    end else begin
      done_zero <= 1'b0;
      rd_vld    <= rd_go;

      if (pop) out_left <= out_left - 16'd1;

      case (state)
        IDLE: begin
          if (start) begin
            if (word_count != 16'd0) begin
              addr       <= start_addr;
              issue_left <= word_count;
              out_left   <= word_count;
              total      <= word_count;
              state      <= FETCH;
            end else begin
              done_zero  <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (rd_go) begin
            addr       <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
            issue_left <= issue_left - 16'd1;
            if (issue_left == 16'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_acc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule
